// File: rtl/cpu_sync_out_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sync_out_pkg
//  Purpose  : Shared constants and types for the CPU sync output generator:
//             register map, CONTROL bit positions and timer FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_sync_out_pkg;

  // Avalon register map
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_WIDTH  = 2'd2;
  localparam logic [1:0] ADDR_EVENT  = 2'd3;

  // CONTROL register bit positions
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_ONESHOT_BIT  = 1;
  localparam int CTRL_POLARITY_BIT = 2;
  localparam int CTRL_IRQ_MASK_BIT = 3;

  // EVENT register bit positions
  localparam int EVT_EVENT_BIT = 0;
  localparam int EVT_BUSY_BIT  = 1;

  // Pulse timer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sync_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_sync_out_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sync_out_gen_if
//  Purpose  : Avalon-MM slave bus bundle for the sync output generator.
//  Revision : 1.0  initial release
// ============================================================================
interface cpu_sync_out_gen_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sync_out_gen_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sync_pulse_timer
//  Purpose  : IDLE/HIGH/LOW pulse sequencer with shadowed period/width and a
//             registered, polarity-adjusted sync output.
//  Revision : 1.0  initial release
// ============================================================================
module sync_pulse_timer
  import cpu_sync_out_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int WIDTH_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_periodic,
  input  logic                start_oneshot,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WIDTH_W-1:0]  width,
  input  logic                polarity,
  output logic                pulse,
  output logic                lead_edge,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] c_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] c_TWO = PERIOD_W'(2);

  sync_state_e         r_state, w_state_next;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_next;
  logic [PERIOD_W-1:0] r_per_sh, r_wid_sh;
  logic                r_oneshot_run, w_oneshot_run_next;
  logic                w_latch;
  logic [PERIOD_W-1:0] w_per_eff, w_wid_min1, w_wid_eff;

  // Clamp programmed values so a period always has at least one active and
  // one inactive clock.
  always_comb begin
    w_per_eff  = (period < c_TWO) ? c_TWO : period;
    w_wid_min1 = (width == '0) ? c_ONE : PERIOD_W'(width);
    w_wid_eff  = (w_wid_min1 > (w_per_eff - c_ONE)) ? (w_per_eff - c_ONE) : w_wid_min1;
  end

  // Next-state, counter and period-start decisions.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_latch            = 1'b0;
    lead_edge          = 1'b0;
    w_oneshot_run_next = r_oneshot_run;
    case (r_state)
      ST_IDLE: begin
        if (start_periodic || start_oneshot) begin
          w_state_next       = ST_HIGH;
          w_cnt_next         = '0;
          w_latch            = 1'b1;
          lead_edge          = 1'b1;
          w_oneshot_run_next = !start_periodic;
        end
      end
      ST_HIGH: begin
        w_cnt_next = r_cnt + c_ONE;
        if (r_cnt == (r_wid_sh - c_ONE)) begin
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_cnt == (r_per_sh - c_ONE)) begin
          w_cnt_next = '0;
          if (enable && !r_oneshot_run) begin
            w_state_next = ST_HIGH;
            w_latch      = 1'b1;
            lead_edge    = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter, shadow registers and the registered output pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_per_sh      <= '0;
      r_wid_sh      <= '0;
      r_oneshot_run <= 1'b0;
      pulse         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_oneshot_run <= w_oneshot_run_next;
      if (w_latch) begin
        r_per_sh <= w_per_eff;
        r_wid_sh <= w_wid_eff;
      end
      pulse <= (w_state_next == ST_HIGH) ^ polarity;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/cpu_sync_out_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sync_out_gen
//  Purpose  : Avalon-MM controlled sync pulse generator: register file,
//             sticky edge event with maskable IRQ, and the pulse timer.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_sync_out_gen
  import cpu_sync_out_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int WIDTH_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cpu_sync_out_gen_if.slave        bus,
  output logic                     irq,
  output logic                     out_port
);

  logic                r_enable, r_polarity, r_irq_mask, r_event;
  logic [PERIOD_W-1:0] r_period;
  logic [WIDTH_W-1:0]  r_width;
  logic                w_wr, w_ctrl_wr, w_enable_next, w_polarity_next, w_oneshot_trig;
  logic                w_lead_edge, w_busy;
  logic [31:0]         w_rdata;

  // Write decode; enable and polarity are forwarded from the bus so a write
  // acts on the very next edge.
  always_comb begin
    w_wr            = bus.chipselect && !bus.write_n;
    w_ctrl_wr       = w_wr && (bus.address == ADDR_CTRL);
    w_enable_next   = w_ctrl_wr ? bus.writedata[CTRL_ENABLE_BIT]   : r_enable;
    w_polarity_next = w_ctrl_wr ? bus.writedata[CTRL_POLARITY_BIT] : r_polarity;
    w_oneshot_trig  = w_ctrl_wr && bus.writedata[CTRL_ONESHOT_BIT];
  end

  // Control, period and width registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_polarity <= 1'b0;
      r_irq_mask <= 1'b0;
      r_period   <= '0;
      r_width    <= '0;
    end else if (w_wr) begin
      case (bus.address)
        ADDR_CTRL: begin
          r_enable   <= bus.writedata[CTRL_ENABLE_BIT];
          r_polarity <= bus.writedata[CTRL_POLARITY_BIT];
          r_irq_mask <= bus.writedata[CTRL_IRQ_MASK_BIT];
        end
        ADDR_PERIOD: r_period <= bus.writedata[PERIOD_W-1:0];
        ADDR_WIDTH:  r_width  <= bus.writedata[WIDTH_W-1:0];
        default:     ;
      endcase
    end
  end

  // Sticky event: a leading edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event <= 1'b0;
    end else if (w_lead_edge) begin
      r_event <= 1'b1;
    end else if (w_wr && (bus.address == ADDR_EVENT) && bus.writedata[EVT_EVENT_BIT]) begin
      r_event <= 1'b0;
    end
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        w_rdata[CTRL_ENABLE_BIT]   = r_enable;
        w_rdata[CTRL_POLARITY_BIT] = r_polarity;
        w_rdata[CTRL_IRQ_MASK_BIT] = r_irq_mask;
      end
      ADDR_PERIOD: w_rdata[PERIOD_W-1:0] = r_period;
      ADDR_WIDTH:  w_rdata[WIDTH_W-1:0]  = r_width;
      default: begin
        w_rdata[EVT_EVENT_BIT] = r_event;
        w_rdata[EVT_BUSY_BIT]  = w_busy;
      end
    endcase
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= w_rdata;
    end
  end

  assign irq = r_event & r_irq_mask;

  sync_pulse_timer #(
    .PERIOD_W (PERIOD_W),
    .WIDTH_W  (WIDTH_W)
  ) u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_periodic (w_enable_next),
    .start_oneshot  (w_oneshot_trig),
    .enable         (w_enable_next),
    .period         (r_period),
    .width          (r_width),
    .polarity       (w_polarity_next),
    .pulse          (out_port),
    .lead_edge      (w_lead_edge),
    .busy           (w_busy)
  );

endmodule
`default_nettype wire
